// File: rtl/mprj_logic_high_seq.sv
// mprj_logic_high_seq: staggered ramp-on / reverse ramp-off driver for the user-project enable lines.
`default_nettype none

module mprj_logic_high_seq #(
    parameter int WIDTH       = 463,
    parameter int GROUPS      = 8,
    parameter int STEP_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         en_req,
    input  logic                         force_off,
    output logic [WIDTH-1:0]             HI,
    output logic [$clog2(GROUPS+1)-1:0]  level,
    output logic                         busy,
    output logic                         done
);

    localparam int GSIZE = (WIDTH + GROUPS - 1) / GROUPS;
    localparam int LW    = $clog2(GROUPS + 1);
    localparam int SW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [LW-1:0] LAST_GRP  = LW'(GROUPS);
    localparam logic [LW-1:0] TOP_DROP  = LW'(GROUPS - 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ON        = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [LW-1:0]   r_grp, w_grp_nxt, w_grp_up, w_grp_dn;
    logic [SW-1:0]   r_step, w_step_nxt;
    logic            w_step_last;
    logic [WIDTH-1:0] r_hi, w_hi_nxt;

    assign w_grp_up    = r_grp + LW'(1);
    assign w_grp_dn    = r_grp - LW'(1);
    assign w_step_last = (r_step == LAST_STEP);

    always_comb begin
        w_state_nxt = r_state;
        w_grp_nxt   = r_grp;
        w_step_nxt  = r_step;
        if (force_off) begin
            w_state_nxt = S_IDLE;
            w_grp_nxt   = '0;
            w_step_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en_req) begin
                        w_grp_nxt   = LW'(1);
                        w_step_nxt  = '0;
                        w_state_nxt = (GROUPS == 1) ? S_ON : S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    // A reversal moves one group immediately, then resumes normal pacing.
                    if (!en_req) begin
                        w_grp_nxt   = w_grp_dn;
                        w_step_nxt  = '0;
                        w_state_nxt = (w_grp_dn == '0) ? S_IDLE : S_RAMP_DOWN;
                    end else if (w_step_last) begin
                        w_grp_nxt   = w_grp_up;
                        w_step_nxt  = '0;
                        w_state_nxt = (w_grp_up == LAST_GRP) ? S_ON : S_RAMP_UP;
                    end else begin
                        w_step_nxt  = r_step + SW'(1);
                    end
                end
                S_ON: begin
                    if (!en_req) begin
                        w_grp_nxt   = TOP_DROP;
                        w_step_nxt  = '0;
                        w_state_nxt = (GROUPS == 1) ? S_IDLE : S_RAMP_DOWN;
                    end
                end
                S_RAMP_DOWN: begin
                    if (en_req) begin
                        w_grp_nxt   = w_grp_up;
                        w_step_nxt  = '0;
                        w_state_nxt = (w_grp_up == LAST_GRP) ? S_ON : S_RAMP_UP;
                    end else if (w_step_last) begin
                        w_grp_nxt   = w_grp_dn;
                        w_step_nxt  = '0;
                        w_state_nxt = (w_grp_dn == '0) ? S_IDLE : S_RAMP_DOWN;
                    end else begin
                        w_step_nxt  = r_step + SW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_grp_nxt   = '0;
                    w_step_nxt  = '0;
                end
            endcase
        end
    end

    // HI is decoded from the next group count so it moves on the same edge as level.
    for (genvar i = 0; i < WIDTH; i++) begin : g_hi
        localparam logic [LW-1:0] GI = LW'(i / GSIZE);
        assign w_hi_nxt[i] = (w_grp_nxt > GI);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_grp   <= '0;
            r_step  <= '0;
            r_hi    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grp   <= w_grp_nxt;
            r_step  <= w_step_nxt;
            r_hi    <= w_hi_nxt;
        end
    end

    assign HI    = r_hi;
    assign level = r_grp;
    assign busy  = (r_state == S_RAMP_UP) || (r_state == S_RAMP_DOWN);
    assign done  = (r_state == S_ON);

endmodule

`default_nettype wire

// File: doc/mprj_logic_high_seq.md
Name: mprj_logic_high_seq

Overview:
Parametrised successor to the static tie-high enable array. It drives WIDTH user-project enable lines. Instead of asserting them all at once, it ramps them on in GROUPS staggered groups, one group every STEP_CYCLES clocks, to limit simultaneous switching and inrush. On disable it ramps them off in reverse order. It sits between management-side enable control and the user-area gating logic, and exposes level/busy/done status.

Parameters:
WIDTH, 463, number of enable outputs (>=1)
GROUPS, 8, number of ramp groups (1..WIDTH)
STEP_CYCLES, 16, clocks between successive group transitions (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
en_req  input  1  level request: 1 = ramp enables on, 0 = ramp off
force_off  input  1  synchronous kill: all enables low on next edge
HI  output  WIDTH  registered enable lines
level  output  clog2(GROUPS+1)  number of groups currently asserted (grp_cnt)
busy  output  1  ramp in progress (RAMP_UP or RAMP_DOWN)
done  output  1  all groups asserted (state ON)

Behaviour:
- GSIZE = ceil(WIDTH/GROUPS). Group g covers bits [g*GSIZE .. min((g+1)*GSIZE, WIDTH)-1]. The last group may be short. Trailing groups may be empty if GSIZE*(GROUPS-1) >= WIDTH; they still take a step slot.
- HI[i] = ((i / GSIZE) < grp_cnt). HI is registered from grp_cnt, so HI and level change on the same edge.
- Reset (resetn low, async): state=IDLE, grp_cnt=0, step_cnt=0. Outputs: HI=0, level=0, busy=0, done=0.
- step_cnt counts 0..STEP_CYCLES-1 while busy. Each completed step (step_cnt == STEP_CYCLES-1) moves grp_cnt by one and clears step_cnt.
- FSM states: IDLE, RAMP_UP, ON, RAMP_DOWN.
  - IDLE: if en_req at edge k, then grp_cnt=1 and state=RAMP_UP (GROUPS>1) or ON (GROUPS==1), step_cnt=0. Group 0 is high after edge k.
  - RAMP_UP: group g asserts at edge k + g*STEP_CYCLES. When grp_cnt becomes GROUPS, go to ON on that same edge.
  - ON: hold while en_req=1. If en_req=0 at edge m: grp_cnt=GROUPS-1 and the top group drops at edge m. State becomes RAMP_DOWN, or IDLE if the result is 0.
  - RAMP_DOWN: grp_cnt decrements every STEP_CYCLES. When it reaches 0, go to IDLE on that edge.
- Reversal mid-ramp:
  - en_req=0 sampled in RAMP_UP: decrement grp_cnt immediately, clear step_cnt, go to RAMP_DOWN (IDLE if 0).
  - en_req=1 sampled in RAMP_DOWN: increment grp_cnt immediately, clear step_cnt, go to RAMP_UP (ON if it reaches GROUPS).
  - A reversal edge never moves grp_cnt by more than 1.
- force_off=1 at any edge: grp_cnt=0, step_cnt=0, state=IDLE. It has priority over en_req. The ramp restarts on the first edge with force_off=0 and en_req=1.
- Status:
  - busy = (state==RAMP_UP || state==RAMP_DOWN).
  - done = (state==ON).
  - level never exceeds GROUPS and never underflows below 0.
- Reset asserted mid-ramp clears everything asynchronously, with no ramp-down sequencing.

Test Plan:
All tests use WIDTH=10, GROUPS=4 (GSIZE=3), STEP_CYCLES=3.
1. Reset: hold resetn low with en_req=1 -> HI=0, level=0, busy=0, done=0. Release resetn mid-cycle -> no output change until the next clk edge.
2. Ramp up: en_req=1 sampled at edge 0 -> HI=0x007 at e0, 0x03F at e3, 0x1FF at e6, 0x3FF at e9. done=1 and busy=0 from e9. level = 1, 2, 3, 4.
3. Ramp down: from ON, en_req=0 at edge 0 -> HI=0x1FF at e0, 0x03F at e3, 0x007 at e6, 0x000 at e9. State IDLE from e9.
4. Reversal: en_req=1 at e0, then en_req=0 at e4 (level=2) -> level=1 at e4, HI=0x007, level=0 at e7. Then en_req=1 at e8 -> level=1 at e8.
5. force_off: mid RAMP_UP at level=3, force_off=1 for one edge -> HI=0, level=0, IDLE. With en_req still 1, the next edge gives level=1.
6. Corners:
   - GROUPS=1: en_req=1 -> HI=0x3FF after one edge, done=1.
   - WIDTH=10, GROUPS=10, STEP_CYCLES=1: one bit per cycle, level reaches 10 at e9.
